// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: takes a word over a valid/ready load
// handshake and shifts it out one bit per enabled clock with valid/last flags.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             sout_q;
    logic             valid_q;

    logic             cnt_zero;
    logic             handshake;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] sr_shifted;

    assign cnt_zero   = (cnt == '0);
    assign load_ready = (state == IDLE) | ((state == SHIFT) & cnt_zero & shift_en);
    assign handshake  = load_valid & load_ready;

    // The output end of the shift register is bit WIDTH-1 for MSB-first, bit 0 otherwise.
    assign first_bit  = MSB_FIRST ? din[WIDTH-1] : din[0];
    assign next_bit   = MSB_FIRST ? sr[WIDTH-2] : sr[1];
    assign sr_shifted = MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            sout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        sr      <= din;
                        sout_q  <= first_bit;
                        cnt     <= LAST_CNT;
                        valid_q <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (!cnt_zero) begin
                            sr     <= sr_shifted;
                            sout_q <= next_bit;
                            cnt    <= cnt - 1'b1;
                        // Reloading on the last bit gives back-to-back words with no gap.
                        end else if (handshake) begin
                            sr      <= din;
                            sout_q  <= first_bit;
                            cnt     <= LAST_CNT;
                            valid_q <= 1'b1;
                        end else begin
                            sout_q  <= 1'b0;
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    sout_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign sout       = sout_q;
    assign sout_valid = valid_q;
    assign sout_last  = valid_q & cnt_zero;
    assign busy       = (state == SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance share one
// stimulus stream and are checked against a word/bit-index reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       load_valid;
    logic       shift_en;

    logic load_ready_m, sout_m, sout_valid_m, sout_last_m, busy_m;
    logic load_ready_l, sout_l, sout_valid_l, sout_last_l, busy_l;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: the word in flight and the send-order index of the bit on the line.
    bit       m_active = 1'b0;
    bit [7:0] m_word   = 8'h00;
    int       m_k      = 0;

    logic obs_ready_m, obs_ready_l, exp_ready;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(load_ready_m), .shift_en(shift_en), .sout(sout_m),
        .sout_valid(sout_valid_m), .sout_last(sout_last_m), .busy(busy_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .din(din), .load_valid(load_valid),
        .load_ready(load_ready_l), .shift_en(shift_en), .sout(sout_l),
        .sout_valid(sout_valid_l), .sout_last(sout_last_l), .busy(busy_l)
    );

    function automatic logic [9:0] exp_vec();
        logic last;
        logic bm;
        logic bl;
        last = m_active && (m_k == 7);
        bm   = m_active ? m_word[7 - m_k] : 1'b0;
        bl   = m_active ? m_word[m_k] : 1'b0;
        return {exp_ready, exp_ready, m_active, last, m_active, bm, m_active, last, m_active, bl};
    endfunction

    function automatic logic [9:0] obs_vec();
        return {obs_ready_m, obs_ready_l, sout_valid_m, sout_last_m, busy_m, sout_m,
                sout_valid_l, sout_last_l, busy_l, sout_l};
    endfunction

    // One clock: drive inputs, sample combinational ready, advance the model on the edge.
    task automatic cycle(input logic rst, input logic lv, input logic [7:0] d, input logic se);
        rst_n      = rst;
        load_valid = lv;
        din        = d;
        shift_en   = se;
        #1;
        obs_ready_m = load_ready_m;
        obs_ready_l = load_ready_l;
        exp_ready   = !m_active || (m_k == 7 && se);
        @(posedge clk);
        if (!rst) begin
            m_active = 1'b0;
            m_k      = 0;
        end else if (lv && exp_ready) begin
            m_active = 1'b1;
            m_word   = d;
            m_k      = 0;
        end else if (m_active && se) begin
            if (m_k == 7) m_active = 1'b0;
            else          m_k++;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b1, 8'($urandom), 1'b1);
            e = exp_vec();
            n_checks++;
            if (obs_vec() !== {2'bxx, 8'h00} && obs_vec()[7:0] !== e[7:0])
                $display("[TB] FAIL reset_outputs cycle %0d: got %b expected %b", i, obs_vec()[7:0], e[7:0]);
            else
                n_pass++;
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (obs_ready_m !== 1'b1 || obs_ready_l !== 1'b1)
            $display("[TB] FAIL reset_ready: got %b%b expected 11", obs_ready_m, obs_ready_l);
        else
            n_pass++;
    endtask

    task automatic test_msb_first();
        logic [7:0] col = 8'h00;
        int nlast = 0;
        cycle(1'b1, 1'b1, 8'hA5, 1'b1);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("[TB] FAIL msb_a5 cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            else
                n_pass++;
            if (sout_valid_m === 1'b1) col = {col[6:0], sout_m};
            if (sout_last_m === 1'b1) nlast++;
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (col !== 8'hA5 || nlast != 1 || sout_valid_m !== 1'b0)
            $display("[TB] FAIL msb_a5_stream: got %h last=%0d expected a5 last=1", col, nlast);
        else
            n_pass++;
    endtask

    task automatic test_lsb_first();
        logic [7:0] col = 8'h00;
        cycle(1'b1, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("[TB] FAIL lsb_01 cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            else
                n_pass++;
            if (sout_valid_l === 1'b1) col = {sout_l, col[7:1]};
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
        n_checks++;
        if (col !== 8'h01)
            $display("[TB] FAIL lsb_01_stream: got %h expected 01", col);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back();
        int nvalid = 0;
        int nones  = 0;
        cycle(1'b1, 1'b1, 8'hFF, 1'b1);
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("[TB] FAIL back_to_back cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            else
                n_pass++;
            if (sout_valid_m === 1'b1) begin
                nvalid++;
                if (sout_m === 1'b1) nones++;
            end
            cycle(1'b1, (i < 8), 8'h00, 1'b1);
        end
        n_checks++;
        if (nvalid != 16 || nones != 8)
            $display("[TB] FAIL back_to_back_count: got %0d valid %0d ones expected 16 valid 8 ones", nvalid, nones);
        else
            n_pass++;
    endtask

    task automatic test_stall();
        logic [7:0] col = 8'h00;
        int nen = 0;
        logic se;
        cycle(1'b1, 1'b1, 8'hC3, 1'b1);
        for (int i = 0; i < 13; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("[TB] FAIL stall cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            else
                n_pass++;
            se = !(i >= 1 && i <= 3);
            if (se && sout_valid_m === 1'b1) begin
                col = {col[6:0], sout_m};
                nen++;
            end
            cycle(1'b1, 1'b0, 8'h00, se);
        end
        n_checks++;
        if (col !== 8'hC3 || nen != 8)
            $display("[TB] FAIL stall_stream: got %h over %0d enabled expected c3 over 8", col, nen);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        cycle(1'b1, 1'b1, 8'h5A, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'hFF, 1'b1);
        n_checks++;
        if (obs_vec()[7:0] !== exp_vec()[7:0] || sout_valid_m !== 1'b0 || busy_m !== 1'b0 || sout_last_m !== 1'b0)
            $display("[TB] FAIL reset_mid_frame: got %b expected %b", obs_vec()[7:0], exp_vec()[7:0]);
        else
            n_pass++;
        cycle(1'b1, 1'b1, 8'h81, 1'b1);
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("[TB] FAIL after_reset_81 cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            else
                n_pass++;
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 31) != 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), ($urandom_range(0, 3) != 0));
            n_checks++;
            if (obs_vec() !== exp_vec())
                $display("[TB] FAIL random cycle %0d: got %b expected %b", i, obs_vec(), exp_vec());
            else
                n_pass++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        din        = 8'h00;
        shift_en   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_stall();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
